// File: rtl/priority_decoder_pkg.sv
// Shared types and constants for the 3-bit priority decoder.
package priority_decoder_pkg;

  localparam int IDX_W   = 2;
  localparam int N_LINES = 3;
  localparam int CNT_W   = 4;

  localparam logic [IDX_W-1:0] IDX_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Map an encoded index to its grant line; the illegal code maps to no line.
  function automatic logic [N_LINES-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_LINES-1:0] oh;
    oh = '0;
    case (idx)
      2'b00:   oh = 3'b001;
      2'b01:   oh = 3'b010;
      2'b10:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/priority_decoder_3bit_idx_fifo.sv
// Small synchronous FIFO for buffered request indices. dout shows the head
// entry combinationally, so a pop consumes the value visible in that cycle.
module idx_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/priority_decoder_3bit.sv
// Replays buffered encoded indices as fixed-length one-hot pulses with one
// idle cycle between pulses.
//
// Handshake: a transfer happens at a rising edge where in_valid && in_ready;
// in_ready depends only on registered FIFO occupancy, never on in_valid.
module priority_decoder_3bit
  import priority_decoder_pkg::*;
#(
  parameter int PULSE_LEN  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N_LINES-1:0] out_onehot,
  output logic               busy,
  output logic               err_idx,
  input  logic               err_clr,
  output logic [1:0]         dbg_state
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             illegal_acc;
  logic             fifo_push;
  logic             fifo_pop;
  logic [IDX_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;

  assign in_ready    = !fifo_full;
  assign accept      = in_valid && in_ready;
  assign illegal_acc = accept && (in_idx == IDX_ILLEGAL);
  // Illegal indices complete the handshake but are never queued.
  assign fifo_push   = accept && (in_idx != IDX_ILLEGAL);
  // The FSM pulls the next index only when it is about to start a pulse.
  assign fifo_pop    = !fifo_empty && ((state == IDLE) || (state == GAP));
  assign busy        = (state != IDLE) || (fifo_count != '0);
  assign dbg_state   = state;

  idx_fifo #(
    .W     (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_idx),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Pulse sequencer: IDLE/GAP start a pulse from the FIFO head, PULSE counts it down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      out_onehot <= '0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (!fifo_empty) begin
            state      <= PULSE;
            out_onehot <= idx_to_onehot(fifo_dout);
            cnt        <= CNT_W'(PULSE_LEN - 1);
          end else begin
            state      <= IDLE;
            out_onehot <= '0;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state      <= GAP;
            out_onehot <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          out_onehot <= '0;
        end
      endcase
    end
  end

  // Sticky illegal-index flag; a new illegal accept overrides a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           err_idx <= 1'b0;
    else if (illegal_acc) err_idx <= 1'b1;
    else if (err_clr)     err_idx <= 1'b0;
  end

endmodule

// File: tb/tb_priority_decoder_3bit.sv
// Directed bench for priority_decoder_3bit (PULSE_LEN 4 and PULSE_LEN 1 builds).
module tb_priority_decoder_3bit;
  import priority_decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] in_idx, in_idx1;
  logic       in_valid, in_valid1;
  logic       in_ready, in_ready1;
  logic [2:0] out_onehot, out_onehot1;
  logic       busy, busy1;
  logic       err_idx, err_idx1;
  logic       err_clr, err_clr1;
  logic [1:0] dbg_state, dbg_state1;

  int total  = 0;
  int passed = 0;

  // clock / reset
  always #5 clk = ~clk;

  priority_decoder_3bit #(.PULSE_LEN(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_idx(in_idx), .in_valid(in_valid),
    .in_ready(in_ready), .out_onehot(out_onehot), .busy(busy),
    .err_idx(err_idx), .err_clr(err_clr), .dbg_state(dbg_state)
  );

  priority_decoder_3bit #(.PULSE_LEN(1), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_idx(in_idx1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_onehot(out_onehot1), .busy(busy1),
    .err_idx(err_idx1), .err_clr(err_clr1), .dbg_state(dbg_state1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // advance one edge, then settle for sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present one index until the edge that transfers it
  task automatic send(input logic [1:0] idx);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_idx   = idx;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("send_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_chk(input string tag, input logic [2:0] exp, input int len);
    for (int i = 0; i < len; i++) begin
      step();
      chk(tag, out_onehot, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_idx = '0; in_valid = 1'b0; err_clr = 1'b0;
    in_idx1 = '0; in_valid1 = 1'b0; err_clr1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_onehot", out_onehot, 3'b000);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_idx, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;

    // idle for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_onehot", out_onehot, 3'b000);
      chk("idle_ready", in_ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_err", err_idx, 1'b0);
    end

    // single index 01
    send(2'b01);
    chk("single_pre_onehot", out_onehot, 3'b000);
    chk("single_pre_busy", busy, 1'b1);
    pulse_chk("single_pulse", 3'b010, 4);
    pulse_chk("single_gap", 3'b000, 1);
    chk("single_gap_busy", busy, 1'b1);
    step();
    chk("single_done_busy", busy, 1'b0);

    // back-to-back 00, 10, 01
    send(2'b00);
    send(2'b10);
    chk("b2b_first", out_onehot, 3'b001);
    send(2'b01);
    chk("b2b_full_ready", in_ready, 1'b0);
    chk("b2b_first2", out_onehot, 3'b001);
    pulse_chk("b2b_p0", 3'b001, 2);
    pulse_chk("b2b_g0", 3'b000, 1);
    chk("b2b_gap_ready", in_ready, 1'b0);
    pulse_chk("b2b_p1", 3'b100, 1);
    chk("b2b_ready_back", in_ready, 1'b1);
    pulse_chk("b2b_p1", 3'b100, 3);
    pulse_chk("b2b_g1", 3'b000, 1);
    pulse_chk("b2b_p2", 3'b010, 4);
    pulse_chk("b2b_g2", 3'b000, 1);
    step();
    chk("b2b_done_busy", busy, 1'b0);
    chk("b2b_done_onehot", out_onehot, 3'b000);

    // illegal index between 00 and 10
    send(2'b00);
    send(2'b11);
    chk("ill_err_set", err_idx, 1'b1);
    send(2'b10);
    chk("ill_p0_first", out_onehot, 3'b001);
    pulse_chk("ill_p0", 3'b001, 2);
    pulse_chk("ill_g0", 3'b000, 1);
    pulse_chk("ill_p1", 3'b100, 4);
    pulse_chk("ill_g1", 3'b000, 1);
    step();
    chk("ill_done_busy", busy, 1'b0);
    pulse_chk("ill_no_more", 3'b000, 6);

    // clear colliding with a new illegal accept: set wins
    in_valid = 1'b1; in_idx = 2'b11; err_clr = 1'b1;
    step();
    in_valid = 1'b0; err_clr = 1'b0;
    chk("clr_vs_set_err", err_idx, 1'b1);
    chk("clr_vs_set_busy", busy, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("lone_clr_err", err_idx, 1'b0);

    // reset during second cycle of a 100 pulse with 01 queued
    send(2'b10);
    send(2'b01);
    chk("rst_mid_first", out_onehot, 3'b100);
    step();
    chk("rst_mid_second", out_onehot, 3'b100);
    chk("rst_mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_onehot", out_onehot, 3'b000);
    chk("rst_mid_busy0", busy, 1'b0);
    chk("rst_mid_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_chk("rst_after", 3'b000, 10);
    chk("rst_after_busy", busy, 1'b0);

    // PULSE_LEN = 1 build: 00, 01 back-to-back
    in_valid1 = 1'b1; in_idx1 = 2'b00;
    step();
    in_idx1 = 2'b01;
    step();
    in_valid1 = 1'b0;
    chk("pl1_c0", out_onehot1, 3'b001);
    step();
    chk("pl1_c1", out_onehot1, 3'b000);
    step();
    chk("pl1_c2", out_onehot1, 3'b010);
    step();
    chk("pl1_c3", out_onehot1, 3'b000);
    step();
    chk("pl1_done_busy", busy1, 1'b0);
    chk("pl1_err", err_idx1, 1'b0);

    // report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
